alu_muldiv: RTL
===============

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand/result width; legal values are powers of two from 8 to 64.
REQ-002 Derived localparam SHW = log2(WIDTH) SHALL set the shift-amount width; it is not user-settable.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 valid_i  input  1  SHALL mark a valid operation request.
REQ-006 ready_o  output  1  SHALL mark that a request is accepted this cycle.
REQ-007 op_i  input  5  SHALL select the operation (encoding in REQ-013).
REQ-008 oper1_i, oper2_i  input  WIDTH each  SHALL carry operands A and B.
REQ-009 flush_i  input  1  SHALL abort any in-flight or pending operation.
REQ-010 valid_o  output  1  SHALL mark result_o valid.
REQ-011 ready_i  input  1  SHALL mark that the consumer takes the result.
REQ-012 result_o  output  WIDTH  SHALL carry the registered result; busy_o  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-013 Encoding SHALL be: 0 PASS(A), 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 SGE (signed), 7 SGEU (unsigned), 8 XOR, 9 SRL, 10 SRA (arithmetic, sign-filling), 11 OR, 12 AND, 13 NE, 14 EQ, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU; any other code yields 0.
REQ-014 All shifts SHALL use B[SHW-1:0] only; compare ops SHALL return 0 or 1 zero-extended; ADD/SUB wrap modulo 2^WIDTH.
REQ-015 MUL SHALL return the low WIDTH bits of the 2*WIDTH product; MULH/MULHSU/MULHU the high WIDTH bits with signed×signed, signed×unsigned, unsigned×unsigned operands.
REQ-016 DIV/REM SHALL round toward zero; remainder takes the sign of the dividend.
REQ-017 Divide by zero SHALL give quotient all-ones and remainder = A; signed overflow (A = most-negative, B = -1) SHALL give quotient = A and remainder 0.
REQ-018 FSM states SHALL be IDLE, MUL, DIV, DONE; ready_o = 1 only in IDLE.
REQ-019 Accept = valid_i & ready_o; operands and op_i SHALL be captured on accept and input changes afterwards ignored.
REQ-020 IDLE -> DONE on accept of ops 0-15, undefined codes, and the REQ-017 special cases; result registered; valid_o rises the next cycle (latency 1).
REQ-021 IDLE -> MUL or DIV on accept of ops 16-19 or 20-23; iteration SHALL use one shift-add or restoring-subtract step per cycle on magnitudes, with sign correction at the end.
REQ-022 MUL/DIV SHALL spend exactly WIDTH cycles iterating then go to DONE; valid_o rises WIDTH+1 cycles after accept.
REQ-023 DONE: valid_o = 1, result_o stable until valid_o & ready_i, then -> IDLE; a new request is accepted no earlier than the following cycle.
REQ-024 flush_i SHALL have priority over all transitions: from any state -> IDLE next cycle, valid_o low next cycle, result discarded; a request presented with flush_i high is not accepted.
REQ-025 The iteration counter SHALL count WIDTH-1 down to 0 and never wrap within one operation.

Reset
REQ-026 While rst_ni = 0: state IDLE, valid_o = 0, busy_o = 0, result_o = 0, counter = 0; ready_o = 1 after release.
REQ-027 Reset asserted mid-operation SHALL drop valid_o and busy_o immediately, asynchronously, and no stale result SHALL appear after release.

Verification (WIDTH = 32)
REQ-028 ADD 0x7FFFFFFF + 0x00000001 -> result_o 0x80000000, valid_o 1 cycle after accept; SGE A=0xFFFFFFFF B=1 -> 0; SGEU same operands -> 1.
REQ-029 SRA 0x80000000 by B=0x24 (uses 4) -> 0xF8000000; SRL same -> 0x08000000.
REQ-030 A=B=0xFFFFFFFF: MULHU -> 0xFFFFFFFE, MULH -> 0x00000000, MUL -> 0x00000001; valid_o exactly 33 cycles after accept.
REQ-031 DIV 7/0 -> 0xFFFFFFFF and REM 7/0 -> 0x00000007, each 1 cycle after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF after 33 cycles.
REQ-032 Hold ready_i = 0 for 5 cycles in DONE -> result_o and valid_o unchanged, ready_o = 0; raising ready_i -> IDLE next cycle.
REQ-033 flush_i on cycle 10 of a DIVU -> valid_o never asserts for it, ready_o = 1 next cycle; repeat with rst_ni pulsed low mid-MUL -> outputs at REQ-026 values.

Source files
------------

// File: rtl/alu_muldiv.sv
// Single-issue ALU with iterative multiply/divide. ALU ops finish in one cycle;
// MUL*/DIV*/REM* run one shift-add or restoring-subtract step per cycle on magnitudes.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] oper1_i,
  input  logic [WIDTH-1:0] oper2_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_PASS = 5'd0,  OP_ADD  = 5'd1,  OP_SUB    = 5'd2,  OP_SLL   = 5'd3;
  localparam logic [4:0] OP_SLT  = 5'd4,  OP_SLTU = 5'd5,  OP_SGE    = 5'd6,  OP_SGEU  = 5'd7;
  localparam logic [4:0] OP_XOR  = 5'd8,  OP_SRL  = 5'd9,  OP_SRA    = 5'd10, OP_OR    = 5'd11;
  localparam logic [4:0] OP_AND  = 5'd12, OP_NE   = 5'd13, OP_EQ     = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_DIV  = 5'd20, OP_DIVU = 5'd21, OP_REM    = 5'd22, OP_REMU  = 5'd23;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [4:0]       op_q;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] hi, lo, opb;

  logic             is_mul, is_div, div_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, imm_res;
  logic [SHW-1:0]   sh;

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);
  assign busy_o  = (state != IDLE);

  assign is_mul   = (op_i[4:2] == 3'b100);
  assign is_div   = (op_i[4:2] == 3'b101);
  assign div_sgn  = (op_i == OP_DIV) || (op_i == OP_REM);
  assign a_neg    = oper1_i[WIDTH-1] & (is_mul ? (op_i == OP_MULH || op_i == OP_MULHSU) : div_sgn);
  assign b_neg    = oper2_i[WIDTH-1] & (is_mul ? (op_i == OP_MULH) : div_sgn);
  assign a_mag    = a_neg ? -oper1_i : oper1_i;
  assign b_mag    = b_neg ? -oper2_i : oper2_i;
  assign div_zero = (oper2_i == '0);
  assign div_ovf  = div_sgn && (oper1_i == MOST_NEG) && (&oper2_i);
  assign sh       = oper2_i[SHW-1:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    imm_res = '0;
    case (op_i)
      OP_PASS: imm_res = oper1_i;
      OP_ADD:  imm_res = oper1_i + oper2_i;
      OP_SUB:  imm_res = oper1_i - oper2_i;
      OP_SLL:  imm_res = oper1_i << sh;
      OP_SLT:  imm_res = WIDTH'($signed(oper1_i) <  $signed(oper2_i));
      OP_SLTU: imm_res = WIDTH'(oper1_i <  oper2_i);
      OP_SGE:  imm_res = WIDTH'($signed(oper1_i) >= $signed(oper2_i));
      OP_SGEU: imm_res = WIDTH'(oper1_i >= oper2_i);
      OP_XOR:  imm_res = oper1_i ^ oper2_i;
      OP_SRL:  imm_res = oper1_i >> sh;
      OP_SRA:  imm_res = $signed(oper1_i) >>> sh;
      OP_OR:   imm_res = oper1_i | oper2_i;
      OP_AND:  imm_res = oper1_i & oper2_i;
      OP_NE:   imm_res = WIDTH'(oper1_i != oper2_i);
      OP_EQ:   imm_res = WIDTH'(oper1_i == oper2_i);
      // Divide special cases resolve in one cycle; the iterative path never sees them.
      OP_DIV, OP_DIVU: imm_res = div_zero ? '1 : oper1_i;
      OP_REM, OP_REMU: imm_res = div_zero ? oper1_i : '0;
      default: imm_res = '0;
    endcase
  end

  // Multiply step: {hi,lo} holds partial product and remaining multiplier bits.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_fin, prod_cor;
  logic [WIDTH-1:0]   mul_res;

  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
  assign prod_fin = {mul_sum, lo[WIDTH-1:1]};
  assign prod_cor = neg_q ? -prod_fin : prod_fin;
  assign mul_res  = (op_q == OP_MUL) ? prod_cor[WIDTH-1:0] : prod_cor[2*WIDTH-1:WIDTH];

  // Divide step: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  logic             div_ok;
  logic [WIDTH-1:0] r_next, q_next, div_res;

  assign div_ok  = {hi, lo[WIDTH-1]} >= {1'b0, opb};
  assign r_next  = {hi[WIDTH-2:0], lo[WIDTH-1]} - (div_ok ? opb : '0);
  assign q_next  = {lo[WIDTH-2:0], div_ok};
  assign div_res = op_q[1] ? (neg_r ? -r_next : r_next) : (neg_q ? -q_next : q_next);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opb      <= '0;
      result_o <= '0;
    end else if (flush_i) begin
      state    <= IDLE;
      cnt      <= '0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          op_q  <= op_i;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          hi    <= '0;
          if (is_mul) begin
            state <= MUL;
            cnt   <= SHW'(WIDTH - 1);
            opb   <= a_mag;
            lo    <= b_mag;
          end else if (is_div && !div_zero && !div_ovf) begin
            state <= DIV;
            cnt   <= SHW'(WIDTH - 1);
            opb   <= b_mag;
            lo    <= a_mag;
          end else begin
            state    <= DONE;
            result_o <= imm_res;
          end
        end
        MUL: begin
          hi <= mul_sum[WIDTH:1];
          lo <= {mul_sum[0], lo[WIDTH-1:1]};
          if (cnt == '0) begin
            state    <= DONE;
            result_o <= mul_res;
          end else begin
            cnt <= cnt - SHW'(1);
          end
        end
        DIV: begin
          hi <= r_next;
          lo <= q_next;
          if (cnt == '0) begin
            state    <= DONE;
            result_o <= div_res;
          end else begin
            cnt <= cnt - SHW'(1);
          end
        end
        DONE: if (ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
